deck_shuffler: RTL and testbench

DECK_SHUFFLER -- requirements
Module: deck_shuffler

---
 rtl/poker_types.sv | 40 ++++
 rtl/lfsr16.sv | 27 ++
 rtl/deck_shuffler.sv | 107 ++++++++++
 tb/tb_deck_shuffler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/poker_types.sv
// Shared card, deck and shuffler-state types for the poker blocks.
// Card encoding is {rank, suit}, with canonical deck entry i = {i%13, i/13}.
package poker_types;

    localparam int DECK_SIZE = 52;
    localparam int RANK_W    = 4;
    localparam int SUIT_W    = 2;
    localparam int CARD_W    = RANK_W + SUIT_W;
    localparam int IDX_W     = 6;
    localparam int LFSR_W    = 16;
    localparam int PROD_W    = LFSR_W + IDX_W;
    localparam int RANKS     = 13;

    typedef enum logic [RANK_W-1:0] {
        RANK_TWO, RANK_THREE, RANK_FOUR, RANK_FIVE, RANK_SIX, RANK_SEVEN,
        RANK_EIGHT, RANK_NINE, RANK_TEN, RANK_JACK, RANK_QUEEN, RANK_KING,
        RANK_ACE
    } rank_t;

    typedef enum logic [SUIT_W-1:0] {
        SUIT_CLUBS, SUIT_DIAMONDS, SUIT_HEARTS, SUIT_SPADES
    } suit_t;

    typedef struct packed {
        rank_t rank;
        suit_t suit;
    } card_t;

    typedef enum logic [1:0] {
        IDLE, INIT, SHUFFLE, READY
    } state_t;

    function automatic card_t canonicalCard(input int idx);
        card_t c;
        c.rank = rank_t'(RANK_W'(idx % RANKS));
        c.suit = suit_t'(SUIT_W'(idx / RANKS));
        return c;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, shifting right.
// SEED must be nonzero, otherwise the register locks at zero.
module lfsr16
    import poker_types::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [LFSR_W-1:0] state
);

    localparam logic [LFSR_W-1:0] MASK = 16'hB400;

    logic [LFSR_W-1:0] r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SEED;
        end else begin
            r_state <= {1'b0, r_state[LFSR_W-1:1]} ^ (r_state[0] ? MASK : '0);
        end
    end

    assign state = r_state;

endmodule

// File: rtl/deck_shuffler.sv
// 52-card deck with an in-place Fisher-Yates shuffle driven by a running LFSR,
// then sequential draws from a pointer into the shuffled deck.
module deck_shuffler
    import poker_types::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_shuffle,
    input  logic             draw_card,
    output card_t            top_card,
    output logic             is_shuffled,
    output logic [IDX_W-1:0] cards_left,
    output logic             deck_empty
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DECK_SIZE - 1);
    localparam logic [IDX_W-1:0] FULL     = IDX_W'(DECK_SIZE);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    card_t             r_deck [DECK_SIZE];
    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_left;
    logic              r_shuffled;

    logic [LFSR_W-1:0] w_lfsr;
    logic [PROD_W-1:0] w_product;
    logic [IDX_W-1:0]  w_j;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .state (w_lfsr)
    );

    // lfsr/2^16 scaled by (i+1) gives a swap partner uniformly-ish in 0..i.
    assign w_product = PROD_W'(w_lfsr) * PROD_W'(r_idx + ONE);
    assign w_j       = w_product[PROD_W-1:LFSR_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_idx      <= LAST_IDX;
            r_ptr      <= '0;
            r_left     <= '0;
            r_shuffled <= 1'b0;
            for (int k = 0; k < DECK_SIZE; k++) begin
                r_deck[k] <= canonicalCard(k);
            end
        end else if (start_shuffle) begin
            // A restart from any state wins over a simultaneous draw.
            r_state    <= INIT;
            r_ptr      <= '0;
            r_left     <= '0;
            r_shuffled <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                end
                INIT: begin
                    for (int k = 0; k < DECK_SIZE; k++) begin
                        r_deck[k] <= canonicalCard(k);
                    end
                    r_idx   <= LAST_IDX;
                    r_state <= SHUFFLE;
                end
                SHUFFLE: begin
                    if (w_j != r_idx) begin
                        r_deck[r_idx] <= r_deck[w_j];
                        r_deck[w_j]   <= r_deck[r_idx];
                    end
                    if (r_idx == ONE) begin
                        r_state    <= READY;
                        r_ptr      <= '0;
                        r_left     <= FULL;
                        r_shuffled <= 1'b1;
                    end else begin
                        r_idx <= r_idx - ONE;
                    end
                end
                READY: begin
                    // The pointer parks on the last card so top_card holds once empty.
                    if (draw_card && (r_left != '0)) begin
                        r_left <= r_left - ONE;
                        if (r_left > ONE) begin
                            r_ptr <= r_ptr + ONE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign top_card    = r_deck[r_ptr];
    assign is_shuffled = r_shuffled;
    assign cards_left  = r_left;
    assign deck_empty  = r_shuffled && (r_left == '0);

endmodule

// File: tb/tb_deck_shuffler.sv
// Directed bench for deck_shuffler: a whole-deck Fisher-Yates reference model,
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_deck_shuffler;
    import poker_types::*;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_shuffle;
    logic        draw_card;
    card_t       top_card;
    logic        is_shuffled;
    logic [5:0]  cards_left;
    logic        deck_empty;
    logic [5:0]  topBits;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    deck_shuffler #(
        .SEED (SEED)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_shuffle (start_shuffle),
        .draw_card     (draw_card),
        .top_card      (top_card),
        .is_shuffled   (is_shuffled),
        .cards_left    (cards_left),
        .deck_empty    (deck_empty)
    );

    assign topBits = top_card;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] lfsrStep(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Card number c (0..51) is rank c%13 of suit c/13, packed as {rank, suit}.
    function automatic int cardCode(input int c);
        return (c % 13) * 4 + (c / 13);
    endfunction

    logic [15:0] mLfsr;
    int          mDeck    [52];
    int          mPending [52];
    int          mPtr       = 0;
    int          mLeft      = 0;
    int          mEdge      = 0;
    int          mReadyEdge = 0;
    bit          mShuffled  = 1'b0;
    bit          mBusy      = 1'b0;

    // The lfsr value seen at edge N+2+k drives the swap for index 51-k.
    task automatic buildShuffle(input logic [15:0] lfsrAtStart);
        logic [15:0] v;
        int j;
        int t;
        v = lfsrStep(lfsrStep(lfsrAtStart));
        for (int c = 0; c < 52; c++) mPending[c] = c;
        for (int i = 51; i >= 1; i--) begin
            j = (int'(v) * (i + 1)) >> 16;
            t = mPending[i];
            mPending[i] = mPending[j];
            mPending[j] = t;
            v = lfsrStep(v);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mLfsr     = SEED;
            mShuffled = 1'b0;
            mBusy     = 1'b0;
            mLeft     = 0;
            mPtr      = 0;
            mEdge     = 0;
            for (int c = 0; c < 52; c++) mDeck[c] = c;
        end else begin
            if (start_shuffle) begin
                mShuffled  = 1'b0;
                mLeft      = 0;
                mPtr       = 0;
                mBusy      = 1'b1;
                mReadyEdge = mEdge + 52;
                buildShuffle(mLfsr);
            end else if (mBusy && mEdge == mReadyEdge) begin
                mBusy     = 1'b0;
                mShuffled = 1'b1;
                mLeft     = 52;
                mPtr      = 0;
                mDeck     = mPending;
            end else if (mShuffled && draw_card && mLeft > 0) begin
                mLeft--;
                if (mPtr < 51) mPtr++;
            end
            mLfsr = lfsrStep(mLfsr);
            mEdge++;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("is_shuffled", 32'(is_shuffled), 32'(mShuffled));
            checkOutput("cards_left", 32'(cards_left), 32'(mLeft));
            checkOutput("deck_empty", 32'(deck_empty), 32'(mShuffled && mLeft == 0));
            if (!mBusy) checkOutput("top_card", 32'(topBits), cardCode(mDeck[mPtr]));
        end
    end

    task automatic applyStimulus(input logic s, input logic d);
        start_shuffle = s;
        draw_card     = d;
        @(negedge clk);
        start_shuffle = 1'b0;
        draw_card     = 1'b0;
    endtask

    task automatic waitReady(output int k);
        k = 0;
        while (!is_shuffled && k < 200) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int  k;
        int  distinct;
        int  idx;
        bit  notCanon;
        bit  seen [52];
        logic [5:0] held;

        reset         = 1'b1;
        start_shuffle = 1'b0;
        draw_card     = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset is_shuffled", 32'(is_shuffled), 0);
        checkOutput("reset cards_left", 32'(cards_left), 0);
        checkOutput("reset deck_empty", 32'(deck_empty), 0);
        checkOutput("reset top_card", 32'(topBits), 0);

        applyStimulus(1'b1, 1'b0);
        waitReady(k);
        checkOutput("start to ready edges", k, 52);
        checkOutput("ready cards_left", 32'(cards_left), 52);

        distinct = 0;
        notCanon = 1'b0;
        for (int c = 0; c < 52; c++) seen[c] = 1'b0;
        for (int n = 0; n < 52; n++) begin
            idx = int'(topBits[1:0]) * 13 + int'(topBits[5:2]);
            if (topBits[5:2] < 4'd13 && !seen[idx]) begin
                seen[idx] = 1'b1;
                distinct++;
            end
            if (idx != n) notCanon = 1'b1;
            draw_card = 1'b1;
            @(negedge clk);
        end
        draw_card = 1'b0;
        checkOutput("distinct drawn cards", distinct, 52);
        checkOutput("deck differs from canonical", 32'(notCanon), 1);
        checkOutput("cards_left after 52 draws", 32'(cards_left), 0);
        checkOutput("deck_empty after 52 draws", 32'(deck_empty), 1);

        held = topBits;
        applyStimulus(1'b0, 1'b1);
        checkOutput("top_card after 53rd draw", 32'(topBits), 32'(held));
        checkOutput("top_card known after 53rd draw", 32'($isunknown(top_card)), 0);
        checkOutput("cards_left after 53rd draw", 32'(cards_left), 0);

        applyStimulus(1'b1, 1'b0);
        repeat (19) begin
            draw_card = 1'b1;
            @(negedge clk);
        end
        draw_card = 1'b0;
        applyStimulus(1'b1, 1'b0);
        waitReady(k);
        checkOutput("restart to ready edges", k, 52);

        repeat (12) applyStimulus(1'b0, 1'b1);
        checkOutput("cards_left after 12 draws", 32'(cards_left), 40);
        applyStimulus(1'b1, 1'b1);
        checkOutput("cards_left after start+draw", 32'(cards_left), 0);
        waitReady(k);
        checkOutput("start+draw to ready edges", k, 52);
        checkOutput("cards_left after reshuffle", 32'(cards_left), 52);

        applyStimulus(1'b1, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("mid-shuffle reset is_shuffled", 32'(is_shuffled), 0);
        checkOutput("mid-shuffle reset cards_left", 32'(cards_left), 0);
        checkOutput("mid-shuffle reset top_card", 32'(topBits), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        checkOutput("idle after reset is_shuffled", 32'(is_shuffled), 0);
        checkOutput("idle after reset top_card", 32'(topBits), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
